// File: rtl/mem_read_arbiter.sv
// Round-robin share of one AXI-style read port between the i-cache (port 0)
// and d-cache (port 1) refill masters, with one burst in flight at a time.
module mem_read_arbiter #(
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  req0_arvalid,
   input  logic [ADDR_WIDTH-1:0] req0_araddr,
   input  logic [LEN_WIDTH-1:0]  req0_arlen,
   input  logic [3:0]            req0_arid,
   output logic                  req0_arready,
   output logic                  req0_rvalid,
   output logic [DATA_WIDTH-1:0] req0_rdata,
   output logic                  req0_rlast,

   input  logic                  req1_arvalid,
   input  logic [ADDR_WIDTH-1:0] req1_araddr,
   input  logic [LEN_WIDTH-1:0]  req1_arlen,
   input  logic [3:0]            req1_arid,
   output logic                  req1_arready,
   output logic                  req1_rvalid,
   output logic [DATA_WIDTH-1:0] req1_rdata,
   output logic                  req1_rlast,

   output logic                  mem_arvalid,
   output logic [ADDR_WIDTH-1:0] mem_araddr,
   output logic [LEN_WIDTH-1:0]  mem_arlen,
   output logic [3:0]            mem_arid,
   input  logic                  mem_arready,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic [3:0]            mem_rid,
   output logic                  mem_rready,

   output logic                  busy,
   output logic                  grant,
   output logic                  id_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

   state_t                state, state_nxt;
   logic                  last_grant;
   logic [LEN_WIDTH-1:0]  beat_cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [3:0]            id_q;

   logic                  any_req;
   logic                  win_port;
   logic                  beat_hit;
   logic                  beat_miss;
   logic                  beat_last;
   logic [LEN_WIDTH-1:0]  last_idx;

   // A zero beat count still moves one beat, so its final index is 0.
   function automatic logic [LEN_WIDTH-1:0] final_beat_idx(input logic [LEN_WIDTH-1:0] len);
      return (len == '0) ? '0 : len - 1'b1;
   endfunction

   assign any_req   = req0_arvalid | req1_arvalid;
   assign win_port  = (req0_arvalid & req1_arvalid) ? ~last_grant : req1_arvalid;
   assign beat_hit  = (state == DATA) && mem_rvalid && (mem_rid == id_q);
   assign beat_miss = (state == DATA) && mem_rvalid && (mem_rid != id_q);
   assign last_idx  = final_beat_idx(len_q);
   assign beat_last = beat_hit && (beat_cnt == last_idx);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req)     state_nxt = ADDR;
         ADDR:    if (mem_arready) state_nxt = DATA;
         DATA:    if (beat_last)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt   <= '0;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         id_err     <= 1'b0;
      end else begin
         if (state == IDLE && any_req)    grant    <= win_port;
         if (state == ADDR && mem_arready) beat_cnt <= '0;
         if (beat_hit)                    beat_cnt <= beat_cnt + 1'b1;
         if (beat_last)                   last_grant <= grant;
         if (beat_miss)                   id_err   <= 1'b1;
      end
   end

   // Request fields are only observed while in ADDR, so they need no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && any_req) begin
         addr_q <= win_port ? req1_araddr : req0_araddr;
         len_q  <= win_port ? req1_arlen  : req0_arlen;
         id_q   <= win_port ? req1_arid   : req0_arid;
      end
   end

   always_comb begin
      req0_arready = 1'b0;
      req1_arready = 1'b0;
      req0_rvalid  = 1'b0;
      req1_rvalid  = 1'b0;
      req0_rdata   = '0;
      req1_rdata   = '0;
      req0_rlast   = 1'b0;
      req1_rlast   = 1'b0;
      mem_arvalid  = 1'b0;
      mem_araddr   = '0;
      mem_arlen    = '0;
      mem_arid     = '0;
      mem_rready   = 1'b0;
      busy         = 1'b0;
      case (state)
         IDLE: begin
            req0_arready = any_req & ~win_port;
            req1_arready = any_req &  win_port;
         end
         ADDR: begin
            busy        = 1'b1;
            mem_arvalid = 1'b1;
            mem_araddr  = addr_q;
            mem_arlen   = len_q;
            mem_arid    = id_q;
         end
         DATA: begin
            busy       = 1'b1;
            mem_rready = 1'b1;
            if (beat_hit) begin
               if (grant) begin
                  req1_rvalid = 1'b1;
                  req1_rdata  = mem_rdata;
                  req1_rlast  = beat_last;
               end else begin
                  req0_rvalid = 1'b1;
                  req0_rdata  = mem_rdata;
                  req0_rlast  = beat_last;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_read_arbiter;

   localparam int AW = 26;
   localparam int DW = 32;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_arvalid, req1_arvalid;
   logic [AW-1:0] req0_araddr,  req1_araddr;
   logic [LW-1:0] req0_arlen,   req1_arlen;
   logic [3:0]    req0_arid,    req1_arid;
   logic          req0_arready, req1_arready;
   logic          req0_rvalid,  req1_rvalid;
   logic [DW-1:0] req0_rdata,   req1_rdata;
   logic          req0_rlast,   req1_rlast;
   logic          mem_arvalid;
   logic [AW-1:0] mem_araddr;
   logic [LW-1:0] mem_arlen;
   logic [3:0]    mem_arid;
   logic          mem_arready;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic [3:0]    mem_rid;
   logic          mem_rready;
   logic          busy, grant, id_err;

   always #5 clk = ~clk;

   mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .req0_arvalid(req0_arvalid), .req0_araddr(req0_araddr), .req0_arlen(req0_arlen),
      .req0_arid(req0_arid), .req0_arready(req0_arready), .req0_rvalid(req0_rvalid),
      .req0_rdata(req0_rdata), .req0_rlast(req0_rlast),
      .req1_arvalid(req1_arvalid), .req1_araddr(req1_araddr), .req1_arlen(req1_arlen),
      .req1_arid(req1_arid), .req1_arready(req1_arready), .req1_rvalid(req1_rvalid),
      .req1_rdata(req1_rdata), .req1_rlast(req1_rlast),
      .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
      .mem_arid(mem_arid), .mem_arready(mem_arready), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .mem_rid(mem_rid), .mem_rready(mem_rready),
      .busy(busy), .grant(grant), .id_err(id_err)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // reference model: one transaction in flight, beats remaining counted down
   bit          m_busy, m_aph, m_owner, m_lastg, m_iderr, m_fresh;
   int          m_left;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_len;
   logic [3:0]    m_id;

   bit            pend0, pend1;
   logic [AW-1:0] a0, a1;
   logic [LW-1:0] l0, l1;
   logic [3:0]    i0, i1;
   int            p_arready, p_rvalid, p_badid, p_req;
   logic [3:0]    rid_q[$];
   bit            want_rst;
   bit            e_ar0, e_ar1, obs_ar0, obs_ar1;
   int            beats_cnt, last_burst_beats;
   bit            winners[$];

   function automatic logic [LW-1:0] rand_len();
      int r;
      r = $urandom_range(9);
      if (r == 0) return 4'd0;
      if (r == 1) return 4'd15;
      return 4'($urandom_range(1, 6));
   endfunction

   task automatic step();
      logic x0, x1, v0, v1, q0, q1, has, win;
      logic [DW-1:0] d0, d1;
      x0 = 0; x1 = 0; v0 = 0; v1 = 0; q0 = 0; q1 = 0; d0 = '0; d1 = '0;
      has = req0_arvalid | req1_arvalid;
      win = (req0_arvalid & req1_arvalid) ? ~m_lastg : req1_arvalid;
      if (!m_busy) begin
         x0 = has & ~win;
         x1 = has & win;
      end else if (!m_aph && mem_rvalid && mem_rid == m_id) begin
         if (m_owner) begin v1 = 1; d1 = mem_rdata; q1 = (m_left == 1); end
         else         begin v0 = 1; d0 = mem_rdata; q0 = (m_left == 1); end
      end
      e_ar0 = x0;
      e_ar1 = x1;
      #1;
      check_eq("p0_ctl", {req0_arready, req0_rvalid, req0_rlast}, {x0, v0, q0});
      check_eq("p1_ctl", {req1_arready, req1_rvalid, req1_rlast}, {x1, v1, q1});
      check_eq("mem_ctl", {mem_arvalid, mem_rready, busy, grant, id_err},
               {m_busy & m_aph, m_busy & ~m_aph, m_busy, m_owner, m_iderr});
      if ((m_busy && m_aph) || m_fresh)
         check_eq("mem_ar", {mem_araddr, mem_arlen, mem_arid},
                  m_fresh ? 64'd0 : {30'd0, m_addr, m_len, m_id});
      if (v0 || m_owner || m_fresh)  check_eq("p0_rdata", req0_rdata, d0);
      if (v1 || !m_owner || m_fresh) check_eq("p1_rdata", req1_rdata, d1);
      obs_ar0 = req0_arready;
      obs_ar1 = req1_arready;
      if (req0_rvalid || req1_rvalid) beats_cnt++;
      if (req0_rlast || req1_rlast) begin
         last_burst_beats = beats_cnt;
         beats_cnt = 0;
      end
      @(posedge clk);
      if (rst) begin
         m_busy = 0; m_aph = 0; m_owner = 0; m_lastg = 1; m_iderr = 0; m_fresh = 1;
         beats_cnt = 0;
      end else if (!m_busy) begin
         if (has) begin
            m_busy = 1; m_aph = 1; m_owner = win; m_fresh = 0;
            m_addr = win ? req1_araddr : req0_araddr;
            m_len  = win ? req1_arlen  : req0_arlen;
            m_id   = win ? req1_arid   : req0_arid;
            m_left = (m_len == 0) ? 1 : int'(m_len);
         end
      end else if (m_aph) begin
         if (mem_arready) m_aph = 0;
      end else if (mem_rvalid) begin
         if (mem_rid == m_id) begin
            m_left--;
            if (m_left == 0) begin m_busy = 0; m_lastg = m_owner; end
         end else m_iderr = 1;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      rst = want_rst;
      if (!pend0 && $urandom_range(99) < p_req) begin
         pend0 = 1; a0 = AW'($urandom); l0 = rand_len(); i0 = 4'($urandom);
      end
      if (!pend1 && $urandom_range(99) < p_req) begin
         pend1 = 1; a1 = AW'($urandom); l1 = rand_len(); i1 = 4'($urandom);
      end
      req0_arvalid = pend0; req0_araddr = a0; req0_arlen = l0; req0_arid = i0;
      req1_arvalid = pend1; req1_araddr = a1; req1_arlen = l1; req1_arid = i1;
      mem_arready = ($urandom_range(99) < p_arready);
      mem_rvalid  = ($urandom_range(99) < p_rvalid);
      mem_rdata   = $urandom;
      if (m_busy && !m_aph && mem_rvalid && rid_q.size() > 0) mem_rid = rid_q.pop_front();
      else if ($urandom_range(99) < p_badid)                 mem_rid = m_id + 4'($urandom_range(1, 15));
      else                                                   mem_rid = m_id;
      step();
      if (!rst) begin
         if (e_ar0) pend0 = 0;
         if (e_ar1) pend1 = 0;
      end
   endtask

   task automatic drain();
      p_arready = 100; p_rvalid = 100; p_req = 0; p_badid = 0;
      for (int k = 0; k < 200 && (m_busy || pend0 || pend1); k++) cycle();
      cycle();
      check_eq("drain", {m_busy, pend0, pend1}, 0);
   endtask

   task automatic set_req(input bit port, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [3:0] id);
      if (port) begin pend1 = 1; a1 = a; l1 = l; i1 = id; end
      else      begin pend0 = 1; a0 = a; l0 = l; i0 = id; end
   endtask

   initial begin
      rst = 1; want_rst = 0;
      req0_arvalid = 0; req0_araddr = '0; req0_arlen = '0; req0_arid = '0;
      req1_arvalid = 0; req1_araddr = '0; req1_arlen = '0; req1_arid = '0;
      mem_arready = 0; mem_rvalid = 0; mem_rdata = '0; mem_rid = '0;
      pend0 = 0; pend1 = 0; a0 = '0; a1 = '0; l0 = '0; l1 = '0; i0 = '0; i1 = '0;
      p_arready = 100; p_rvalid = 100; p_badid = 0; p_req = 0;
      beats_cnt = 0; last_burst_beats = 0;
      repeat (3) @(posedge clk);
      m_busy = 0; m_aph = 0; m_owner = 0; m_lastg = 1; m_iderr = 0; m_fresh = 1;
      m_left = 0; m_addr = '0; m_len = '0; m_id = '0;

      // reset state and idle
      repeat (3) cycle();

      // single port-0 burst
      set_req(0, 26'h100, 4'd4, 4'd0);
      for (int k = 0; k < 12; k++) cycle();
      check_eq("single_beats", last_burst_beats, 4);

      // simultaneous requests after reset alternate 0,1,0
      want_rst = 1; cycle(); want_rst = 0;
      winners.delete();
      set_req(0, 26'h200, 4'd2, 4'd3);
      set_req(1, 26'h300, 4'd3, 4'd4);
      for (int k = 0; k < 300 && winners.size() < 3; k++) begin
         if (!pend0 && !pend1 && winners.size() == 2) begin
            set_req(0, 26'h240, 4'd1, 4'd5);
            set_req(1, 26'h340, 4'd1, 4'd6);
         end
         cycle();
         if (obs_ar0 || obs_ar1) winners.push_back(obs_ar1);
      end
      check_eq("alt_count", winners.size(), 3);
      for (int k = 0; k < winners.size() && k < 3; k++)
         check_eq($sformatf("alt_winner%0d", k), winners[k], (k == 1) ? 1 : 0);
      drain();

      // memory stalls the address phase while stray beats arrive
      set_req(1, 26'h3ABCDE, 4'd3, 4'd5);
      p_arready = 0; p_rvalid = 100;
      repeat (6) cycle();
      drain();

      // mismatched ID beat is consumed but not forwarded
      rid_q = '{4'd1, 4'd3, 4'd1};
      set_req(0, 26'h480, 4'd2, 4'd1);
      drain();
      check_eq("id_err_set", id_err, 1);
      repeat (3) cycle();
      check_eq("id_err_sticky", id_err, 1);

      // reset in the middle of a len=8 burst
      set_req(0, 26'h500, 4'd8, 4'd2);
      p_arready = 100; p_rvalid = 100;
      for (int k = 0; k < 40 && !(m_busy && !m_aph && m_left == 6); k++) cycle();
      check_eq("rst_mid_reached", m_left, 6);
      want_rst = 1; cycle(); want_rst = 0;
      repeat (4) cycle();
      check_eq("rst_id_err", id_err, 0);
      set_req(1, 26'h600, 4'd2, 4'd7);
      drain();

      // length boundaries
      set_req(0, 26'h700, 4'd0, 4'd8);
      drain();
      check_eq("len0_beats", last_burst_beats, 1);
      set_req(1, 26'h740, 4'd15, 4'd9);
      drain();
      check_eq("len15_beats", last_burst_beats, 15);

      // randomized traffic
      for (int b = 0; b < 25; b++) begin
         p_arready = $urandom_range(30, 100);
         p_rvalid  = $urandom_range(30, 100);
         p_badid   = $urandom_range(0, 20);
         p_req     = $urandom_range(10, 80);
         for (int k = 0; k < 100; k++) begin
            want_rst = ($urandom_range(299) == 0);
            cycle();
         end
         want_rst = 0;
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares one AXI-style memory read port (AR/R channels) between two cache refill masters: port 0 is the i-cache and port 1 is the d-cache refill path.
- Performs round-robin arbitration and allows only one outstanding burst at a time.
- Forwards each granted burst's data beats back to the owning requester only.
- Sits between the cache refill FSMs and the memory read interface.

Parameters:
ADDR_WIDTH, 26, byte address width of the AR address
DATA_WIDTH, 32, width of one read data beat
LEN_WIDTH, 4, width of the burst-length field; value is the beat count, not beat count minus one

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req0_arvalid  in  1  port 0 read request
req0_araddr  in  ADDR_WIDTH  port 0 line address
req0_arlen  in  LEN_WIDTH  port 0 burst beat count
req0_arid  in  4  port 0 transaction ID
req0_arready  out  1  port 0 request accepted
req0_rvalid  out  1  port 0 data beat valid
req0_rdata  out  DATA_WIDTH  port 0 data beat
req0_rlast  out  1  port 0 final beat of burst
req1_arvalid, req1_araddr, req1_arlen, req1_arid, req1_arready, req1_rvalid, req1_rdata, req1_rlast: identical to port 0, for port 1
mem_arvalid  out  1  memory read request
mem_araddr  out  ADDR_WIDTH  forwarded address
mem_arlen  out  LEN_WIDTH  forwarded beat count
mem_arid  out  4  forwarded ID
mem_arready  in  1  memory accepts request
mem_rvalid  in  1  memory data beat valid
mem_rdata  in  DATA_WIDTH  memory data beat
mem_rid  in  4  ID of the returned beat
mem_rready  out  1  arbiter consumes beat
busy  out  1  a burst is in flight (state != IDLE)
grant  out  1  index of the current or last granted port
id_err  out  1  sticky flag: a beat was received with a mismatched ID

Behaviour:
- Single clock. rst is synchronous and active-high, sampled on posedge clk.
- States: IDLE, ADDR, DATA.
- Reset, including mid-burst:
  - state=IDLE, beat counter=0, last_grant=1 (so port 0 wins the first tie), grant=0, id_err=0.
  - All valid/ready outputs are 0; data and address outputs are 0.
  - An in-flight burst is abandoned; late memory beats are dropped because mem_rready=0 outside DATA.
- IDLE:
  - If exactly one reqN_arvalid is high, that port wins.
  - If both are high, the port != last_grant wins.
  - The winner's reqN_arready=1 in this same cycle; its araddr/arlen/arid and grant are registered; next state ADDR.
  - The loser's arready stays 0, and it must hold arvalid.
  - If neither is valid, stay in IDLE.
- ADDR:
  - mem_arvalid=1, driving the registered fields.
  - On mem_arready go to DATA with counter=0; otherwise hold with all fields stable.
  - mem_rvalid is ignored (mem_rready=0).
- DATA:
  - mem_rready=1.
  - Each mem_rvalid beat with mem_rid==registered ID is forwarded combinationally in the same cycle: req[grant]_rvalid=1, req[grant]_rdata=mem_rdata; then counter increments.
  - req[grant]_rlast=1 on the beat where counter==len-1. After that beat: next state IDLE, last_grant<=grant.
  - A beat with mem_rid != registered ID is consumed but not forwarded and not counted; id_err<=1 (sticky until rst).
- Non-granted port: rvalid=0, rlast=0, rdata=0 at all times.
- arlen==0 is treated as a 1-beat burst.
- The counter is LEN_WIDTH bits; arlen==2^LEN_WIDTH-1 must complete without wrap error.
- Latency:
  - arvalid in cycle t (IDLE) gives mem_arvalid in t+1.
  - Last beat in cycle u returns to IDLE in u+1; the next grant is earliest at u+1, and mem_arvalid earliest at u+2.
- A new arvalid arriving during ADDR/DATA is not acknowledged until IDLE.
- busy=1 in ADDR and DATA. grant holds its value after a burst.

Test Plan:
- Single port-0 request (addr=0x0000100, len=4, id=0): req0_arready at cycle 0, mem_arvalid cycles 1..k with addr 0x100; 4 beats 0xA0..0xA3 forwarded to port 0 only, rlast on 0xA3; busy drops the cycle after.
- Simultaneous requests after reset: port 0 is granted first; port 1 is granted in the IDLE cycle right after port 0's last beat; a third round with both requesting grants port 0 (alternation).
- mem_arready held low 5 cycles in ADDR: mem_arvalid/araddr stable throughout; a stray mem_rvalid during ADDR produces no reqN_rvalid.
- Mismatched ID: burst id=1, len=2, memory returns beats with rid=1, rid=3, rid=1: only the 2 matching beats are forwarded, rlast on the third memory beat; id_err=1 and stays 1.
- rst asserted after beat 2 of a len=8 burst: the next cycle shows state IDLE, all outputs 0, id_err=0; the remaining memory beats are ignored; a new port-1 request is granted normally.
- arlen=0 and arlen=15: the first completes after exactly 1 beat with rlast; the second after 15 beats with rlast on the 15th.
